control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Fetch/decode/execute sequencer for the 8-bit CPU; sits directly upstream of the ALU.
//  Steps through T-states T0..T4 and drives the datapath control word from the current
//  T-state, opcode and flags, including the ALU's alu_en / alu_op and the flags-register
//  load. It consumes the registered carry/zero flags for JC/JZ.
// PARAMETERS
//  OPCODE_W   4  width of instr_opcode (IR upper nibble)
//  TSTATE_W   3  width of t_state; encodes T0..T4, values 5..7 unused
// PORTS
//  clk          in   1         single system clock; all state updates on rising edge
//  rst          in   1         synchronous, active-high reset
//  instr_opcode in   OPCODE_W  IR[7:4]; valid from T2 of each instruction
//  carry_flag   in   1         registered carry from flags register
//  zero_flag    in   1         registered zero from flags register
//  pc_out, pc_inc, pc_load    out 1 each  program counter: drive bus / increment / load from bus
//  mar_load                   out 1       load MAR from bus
//  ram_out, ram_load          out 1 each  RAM: drive bus / write from bus
//  ir_load, ir_out            out 1 each  IR: load from bus / drive IR[3:0] onto bus
//  a_load, a_out, b_load      out 1 each  A register load/drive; B register load
//  alu_en, alu_op             out 1 each  ALU bus drive; alu_op 1=add, 0=sub
//  flags_load                 out 1       latch ALU carry/zero into flags register
//  out_load                   out 1       load output register from bus
//  halt                       out 1       CPU halted; clock gating is external
//  t_state                    out TSTATE_W  current T-state, for debug
// BEHAVIOUR
//  - State: t_state counter and sticky halted bit. Reset: t_state=0, halted=0.
//  - Outputs decode combinationally from t_state, halted and instr_opcode.
//  - While rst=1, every control output and halt is forced to 0.
//  - Fetch, all opcodes:
//      T0: pc_out, mar_load.
//      T1: ram_out, ir_load, pc_inc.
//  - Execute. After an instruction's last T-state, the next cycle is T0 (no idle cycles).
//      0x0 NOP: T2 empty; last=T2.
//      0x1 LDA: T2 ir_out, mar_load; T3 ram_out, a_load; last=T3.
//      0x2 ADD: T2 ir_out, mar_load; T3 ram_out, b_load;
//               T4 alu_en, alu_op=1, a_load, flags_load; last=T4.
//      0x3 SUB: as ADD, except T4 alu_op=0.
//      0x4 STA: T2 ir_out, mar_load; T3 a_out, ram_load; last=T3.
//      0x5 LDI: T2 ir_out, a_load; last=T2.
//      0x6 JMP: T2 ir_out, pc_load; last=T2.
//      0x7 JC:  T2 ir_out, plus pc_load only if carry_flag=1; last=T2.
//      0x8 JZ:  T2 ir_out, plus pc_load only if zero_flag=1; last=T2.
//      0xE OUT: T2 a_out, out_load; last=T2.
//      0xF HLT: T2 halt=1, halted set at the clock edge; last=T2.
//      0x9-0xD: treated as NOP.
//  - alu_op is 0 whenever alu_en=0.
//  - At most one bus driver per cycle: pc_out, ram_out, ir_out, a_out, alu_en are mutually exclusive.
//  - Halted: t_state frozen; halt=1; all other outputs 0. Only rst exits the halted state.
//  - Flags sampled in T2 come from the flags register, i.e. the last ADD/SUB result.
//    No forwarding path.
//  - Reset mid-instruction: the instruction is abandoned.
//    First cycle after rst deasserts is T0; halted is cleared.
//  - t_state never reaches values 5..7. If it is corrupted to such a value, the next state is T0.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg holds:
//      opcode localparams (OP_NOP..OP_HLT);
//      T-state encodings T0..T4;
//      control-word bit indices, so that the bus and the bench share one definition.
//  - One sub-module, microcode_decoder: purely combinational.
//      Inputs: t_state, opcode, flags.
//      Outputs: control word and last_step.
//  - Counter and halted register live in control_sequencer.
// TESTING
//  1. rst held 3 cycles -> all outputs 0, t_state=0. Release -> T0 shows pc_out=1, mar_load=1.
//  2. LDA (0x1): T0..T3 produce the exact signals above; next cycle t_state=0. Cycle count = 4.
//  3. ADD then SUB:
//       ADD T4 -> alu_en=1, alu_op=1, a_load=1, flags_load=1.
//       SUB T4 -> alu_op=0. Each instruction is 5 cycles.
//  4. JC with carry_flag=0 -> pc_load=0 in T2. JC with carry_flag=1 -> pc_load=1, ir_out=1.
//     Repeat for JZ with zero_flag.
//  5. HLT -> halt=1 from T2; 10 further cycles show t_state=2 and all other outputs 0.
//     rst -> halt=0, fetch resumes at T0.
//  6. rst asserted in T3 of ADD -> next cycle all outputs 0. After release, T0; no flags_load is ever seen.
//     Also: opcode 0xB -> 3-cycle NOP.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, T-state encodings
// and control-word bit positions used by the datapath and its bench.
package cpu_ctrl_pkg;

    localparam int OPCODE_BITS = 4;
    localparam int TSTATE_BITS = 3;

    localparam logic [OPCODE_BITS-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_BITS-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_BITS-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_BITS-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_BITS-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_BITS-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_BITS-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_BITS-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_BITS-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_BITS-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_BITS-1:0] OP_HLT = 4'hF;

    localparam logic [TSTATE_BITS-1:0] T0 = 3'd0;
    localparam logic [TSTATE_BITS-1:0] T1 = 3'd1;
    localparam logic [TSTATE_BITS-1:0] T2 = 3'd2;
    localparam logic [TSTATE_BITS-1:0] T3 = 3'd3;
    localparam logic [TSTATE_BITS-1:0] T4 = 3'd4;

    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_LOAD   = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_EN     = 11;
    localparam int CW_ALU_OP     = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_HALT       = 15;
    localparam int CW_W          = 16;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_decoder.sv
// Combinational microcode: maps (T-state, opcode, flags) to the control word
// and flags the final T-state of each instruction.
module microcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [TSTATE_BITS-1:0] t_state,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic                   carry_flag,
    input  logic                   zero_flag,
    output ctrl_word_t             cw,
    output logic                   last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (t_state)
            T0: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
            T1: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw        = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                        last_step = 1'b0;
                    end
                    OP_LDI: cw = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
                    OP_JMP: cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                    OP_JC:  cw = cw_bit(CW_IR_OUT) | (carry_flag ? cw_bit(CW_PC_LOAD) : '0);
                    OP_JZ:  cw = cw_bit(CW_IR_OUT) | (zero_flag ? cw_bit(CW_PC_LOAD) : '0);
                    OP_OUT: cw = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
                    OP_HLT: cw = cw_bit(CW_HALT);
                    default: cw = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw        = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
                        last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
                    OP_STA: begin
                        cw        = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_LOAD);
                        last_step = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    // alu_op only accompanies alu_en, so it is never asserted alone
                    cw = cw_bit(CW_ALU_EN) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD)
                       | ((opcode == OP_ADD) ? cw_bit(CW_ALU_OP) : '0);
                end
            end
            // Corrupted encodings 5..7 fall back to T0 on the next edge
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: T-state counter plus sticky halt, driving the
// datapath control word from the microcode decoder.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int TSTATE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ram_load,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_en,
    output logic                alu_op,
    output logic                flags_load,
    output logic                out_load,
    output logic                halt,
    output logic [TSTATE_W-1:0] t_state
);

    logic [TSTATE_W-1:0] t_q;
    logic [TSTATE_W-1:0] t_next;
    logic                halted_q;
    logic                halted_next;
    ctrl_word_t          dec_cw;
    ctrl_word_t          out_cw;
    logic                last_step;

    microcode_decoder u_decoder (
        .t_state    (t_q),
        .opcode     (instr_opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .cw         (dec_cw),
        .last_step  (last_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q      <= T0;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_next;
            halted_q <= halted_next;
        end
    end

    // HLT freezes the counter from its own T2 onward
    always_comb begin
        halted_next = halted_q | dec_cw[CW_HALT];
        t_next      = t_q;
        if (!halted_next) begin
            t_next = last_step ? T0 : t_q + TSTATE_W'(1);
        end
    end

    always_comb begin
        out_cw = '0;
        if (rst) begin
            out_cw = '0;
        end else if (halted_q) begin
            out_cw[CW_HALT] = 1'b1;
        end else begin
            out_cw = dec_cw;
        end
    end

    assign pc_out     = out_cw[CW_PC_OUT];
    assign pc_inc     = out_cw[CW_PC_INC];
    assign pc_load    = out_cw[CW_PC_LOAD];
    assign mar_load   = out_cw[CW_MAR_LOAD];
    assign ram_out    = out_cw[CW_RAM_OUT];
    assign ram_load   = out_cw[CW_RAM_LOAD];
    assign ir_load    = out_cw[CW_IR_LOAD];
    assign ir_out     = out_cw[CW_IR_OUT];
    assign a_load     = out_cw[CW_A_LOAD];
    assign a_out      = out_cw[CW_A_OUT];
    assign b_load     = out_cw[CW_B_LOAD];
    assign alu_en     = out_cw[CW_ALU_EN];
    assign alu_op     = out_cw[CW_ALU_OP];
    assign flags_load = out_cw[CW_FLAGS_LOAD];
    assign out_load   = out_cw[CW_OUT_LOAD];
    assign halt       = out_cw[CW_HALT];
    assign t_state    = t_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each cycle's T-state and full control
// word are compared against hand-written expectations.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] instr_opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load;
    logic       ir_load, ir_out, a_load, a_out, b_load;
    logic       alu_en, alu_op, flags_load, out_load, halt;
    logic [2:0] t_state;

    int checks = 0;
    int failures = 0;

    control_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_opcode (instr_opcode),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .pc_out       (pc_out),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .mar_load     (mar_load),
        .ram_out      (ram_out),
        .ram_load     (ram_load),
        .ir_load      (ir_load),
        .ir_out       (ir_out),
        .a_load       (a_load),
        .a_out        (a_out),
        .b_load       (b_load),
        .alu_en       (alu_en),
        .alu_op       (alu_op),
        .flags_load   (flags_load),
        .out_load     (out_load),
        .halt         (halt),
        .t_state      (t_state)
    );

    always #5 clk = ~clk;

    ctrl_word_t obs;
    always_comb begin
        obs                = '0;
        obs[CW_PC_OUT]     = pc_out;
        obs[CW_PC_INC]     = pc_inc;
        obs[CW_PC_LOAD]    = pc_load;
        obs[CW_MAR_LOAD]   = mar_load;
        obs[CW_RAM_OUT]    = ram_out;
        obs[CW_RAM_LOAD]   = ram_load;
        obs[CW_IR_LOAD]    = ir_load;
        obs[CW_IR_OUT]     = ir_out;
        obs[CW_A_LOAD]     = a_load;
        obs[CW_A_OUT]      = a_out;
        obs[CW_B_LOAD]     = b_load;
        obs[CW_ALU_EN]     = alu_en;
        obs[CW_ALU_OP]     = alu_op;
        obs[CW_FLAGS_LOAD] = flags_load;
        obs[CW_OUT_LOAD]   = out_load;
        obs[CW_HALT]       = halt;
    end

    function automatic ctrl_word_t b(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

    // Sample at the falling edge, then advance to just past the next rising edge
    task automatic cyc(input string tag, input logic [2:0] exp_t, input ctrl_word_t exp_cw);
        @(negedge clk);
        checks++;
        assert ({t_state, obs} === {exp_t, exp_cw}) else begin
            failures++;
            $error("FAIL %s observed t=%0d cw=%h expected t=%0d cw=%h",
                   tag, t_state, obs, exp_t, exp_cw);
        end
        @(posedge clk);
        #1;
    endtask

    ctrl_word_t f0, f1, irmar, alu_add, alu_sub, none;

    initial begin
        f0      = b(CW_PC_OUT) | b(CW_MAR_LOAD);
        f1      = b(CW_RAM_OUT) | b(CW_IR_LOAD) | b(CW_PC_INC);
        irmar   = b(CW_IR_OUT) | b(CW_MAR_LOAD);
        alu_add = b(CW_ALU_EN) | b(CW_ALU_OP) | b(CW_A_LOAD) | b(CW_FLAGS_LOAD);
        alu_sub = b(CW_ALU_EN) | b(CW_A_LOAD) | b(CW_FLAGS_LOAD);
        none    = '0;

        // reset held 3 cycles
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 3'd0, none);
        rst = 1'b0;

        instr_opcode = OP_LDA;
        cyc("lda_t0", 3'd0, f0);
        cyc("lda_t1", 3'd1, f1);
        cyc("lda_t2", 3'd2, irmar);
        cyc("lda_t3", 3'd3, b(CW_RAM_OUT) | b(CW_A_LOAD));

        instr_opcode = OP_ADD;
        cyc("add_t0", 3'd0, f0);
        cyc("add_t1", 3'd1, f1);
        cyc("add_t2", 3'd2, irmar);
        cyc("add_t3", 3'd3, b(CW_RAM_OUT) | b(CW_B_LOAD));
        cyc("add_t4", 3'd4, alu_add);

        instr_opcode = OP_SUB;
        cyc("sub_t0", 3'd0, f0);
        cyc("sub_t1", 3'd1, f1);
        cyc("sub_t2", 3'd2, irmar);
        cyc("sub_t3", 3'd3, b(CW_RAM_OUT) | b(CW_B_LOAD));
        cyc("sub_t4", 3'd4, alu_sub);

        instr_opcode = OP_JC; carry_flag = 1'b0; zero_flag = 1'b1;
        cyc("jc0_t0", 3'd0, f0);
        cyc("jc0_t1", 3'd1, f1);
        cyc("jc0_t2", 3'd2, b(CW_IR_OUT));
        carry_flag = 1'b1; zero_flag = 1'b0;
        cyc("jc1_t0", 3'd0, f0);
        cyc("jc1_t1", 3'd1, f1);
        cyc("jc1_t2", 3'd2, b(CW_IR_OUT) | b(CW_PC_LOAD));

        instr_opcode = OP_JZ; carry_flag = 1'b1; zero_flag = 1'b0;
        cyc("jz0_t0", 3'd0, f0);
        cyc("jz0_t1", 3'd1, f1);
        cyc("jz0_t2", 3'd2, b(CW_IR_OUT));
        carry_flag = 1'b0; zero_flag = 1'b1;
        cyc("jz1_t0", 3'd0, f0);
        cyc("jz1_t1", 3'd1, f1);
        cyc("jz1_t2", 3'd2, b(CW_IR_OUT) | b(CW_PC_LOAD));
        zero_flag = 1'b0;

        instr_opcode = OP_STA;
        cyc("sta_t0", 3'd0, f0);
        cyc("sta_t1", 3'd1, f1);
        cyc("sta_t2", 3'd2, irmar);
        cyc("sta_t3", 3'd3, b(CW_A_OUT) | b(CW_RAM_LOAD));

        instr_opcode = OP_LDI;
        cyc("ldi_t0", 3'd0, f0);
        cyc("ldi_t1", 3'd1, f1);
        cyc("ldi_t2", 3'd2, b(CW_IR_OUT) | b(CW_A_LOAD));

        instr_opcode = OP_JMP;
        cyc("jmp_t0", 3'd0, f0);
        cyc("jmp_t1", 3'd1, f1);
        cyc("jmp_t2", 3'd2, b(CW_IR_OUT) | b(CW_PC_LOAD));

        instr_opcode = OP_OUT;
        cyc("out_t0", 3'd0, f0);
        cyc("out_t1", 3'd1, f1);
        cyc("out_t2", 3'd2, b(CW_A_OUT) | b(CW_OUT_LOAD));

        instr_opcode = 4'hB;
        cyc("nopb_t0", 3'd0, f0);
        cyc("nopb_t1", 3'd1, f1);
        cyc("nopb_t2", 3'd2, none);

        instr_opcode = OP_NOP;
        cyc("nop_t0", 3'd0, f0);
        cyc("nop_t1", 3'd1, f1);
        cyc("nop_t2", 3'd2, none);

        instr_opcode = OP_HLT;
        cyc("hlt_t0", 3'd0, f0);
        cyc("hlt_t1", 3'd1, f1);
        cyc("hlt_t2", 3'd2, b(CW_HALT));
        // halt is sticky even when the opcode input changes
        instr_opcode = OP_ADD;
        for (int i = 0; i < 10; i++) cyc("halted", 3'd2, b(CW_HALT));
        rst = 1'b1;
        cyc("hlt_rst", 3'd2, none);
        rst = 1'b0;
        cyc("resume_t0", 3'd0, f0);
        cyc("resume_t1", 3'd1, f1);
        cyc("resume_t2", 3'd2, irmar);
        cyc("resume_t3", 3'd3, b(CW_RAM_OUT) | b(CW_B_LOAD));
        cyc("resume_t4", 3'd4, alu_add);

        // reset during T3 of ADD abandons the instruction
        cyc("mid_t0", 3'd0, f0);
        cyc("mid_t1", 3'd1, f1);
        cyc("mid_t2", 3'd2, irmar);
        rst = 1'b1;
        cyc("mid_rst_t3", 3'd3, none);
        cyc("mid_rst_hold", 3'd0, none);
        rst = 1'b0;
        instr_opcode = OP_NOP;
        cyc("post_t0", 3'd0, f0);
        cyc("post_t1", 3'd1, f1);
        cyc("post_t2", 3'd2, none);
        cyc("post_next", 3'd0, f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
